// File: rtl/timer_preset_loader.sv
// timer_preset_loader
//   Keypad-side writer for the countdown timer's serial load port. Key digits
//   are collected into an M:SS entry buffer. On start, the buffer is checked.
//   A valid preset is then shifted into the timer over three loadn-low
//   cycles: minutes first, then tens of seconds, then ones of seconds.
//
// Parameters
//   MAX_TENS    largest legal tens-of-seconds digit
//   MAX_MINS    largest legal minutes digit
//
// Ports
//   clock       system clock, rising edge
//   clear       synchronous active-high reset
//   key_digit   BCD key digit, sampled when key_valid=1
//   key_valid   one-cycle strobe for a new key digit
//   start       one-cycle request to load the entered preset
//   cancel      one-cycle request to discard the entry
//   data_in     digit driven onto the timer's serial load input
//   loadn       active-low load strobe to the timer
//   entry_mins  entry buffer minutes digit, for display
//   entry_tens  entry buffer tens-of-seconds digit, for display
//   entry_ones  entry buffer ones-of-seconds digit, for display
//   busy        high while the load sequence runs
//   load_done   one-cycle pulse when the load completes
//   error       one-cycle pulse when a start is rejected
module timer_preset_loader #(
  parameter int MAX_TENS = 5,
  parameter int MAX_MINS = 9
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [3:0] key_digit,
  input  logic       key_valid,
  input  logic       start,
  input  logic       cancel,
  output logic [3:0] data_in,
  output logic       loadn,
  output logic [3:0] entry_mins,
  output logic [3:0] entry_tens,
  output logic [3:0] entry_ones,
  output logic       busy,
  output logic       load_done,
  output logic       error
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LD_M = 3'd1;
  localparam logic [2:0] LD_T = 3'd2;
  localparam logic [2:0] LD_S = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [3:0] MAX_TENS_D = 4'(MAX_TENS);
  localparam logic [3:0] MAX_MINS_D = 4'(MAX_MINS);

  logic [2:0] state;

  // A preset is loadable when each digit is in range and it is not 0:00.
  function automatic logic preset_ok(input logic [3:0] m,
                                     input logic [3:0] t,
                                     input logic [3:0] o);
    logic nonzero;
    nonzero   = (m != 4'd0) || (t != 4'd0) || (o != 4'd0);
    preset_ok = (t <= MAX_TENS_D) && (m <= MAX_MINS_D) && nonzero;
  endfunction

  // All outputs are registered. Each one is set on the transition into the
  // state that shows it, so that LD_M presents the minutes digit in the
  // first cycle after start is accepted.
  always_ff @(posedge clock) begin
    if (clear) begin
      state      <= IDLE;
      data_in    <= 4'd0;
      loadn      <= 1'b1;
      entry_mins <= 4'd0;
      entry_tens <= 4'd0;
      entry_ones <= 4'd0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      error      <= 1'b0;
    end else begin
      data_in   <= 4'd0;
      loadn     <= 1'b1;
      busy      <= 1'b0;
      load_done <= 1'b0;
      error     <= 1'b0;
      case (state)
        IDLE: begin
          // Only the highest-priority request is acted on in a given cycle.
          if (cancel) begin
            entry_mins <= 4'd0;
            entry_tens <= 4'd0;
            entry_ones <= 4'd0;
          end else if (start) begin
            if (preset_ok(entry_mins, entry_tens, entry_ones)) begin
              state   <= LD_M;
              loadn   <= 1'b0;
              data_in <= entry_mins;
              busy    <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end else if (key_valid && (key_digit <= 4'd9)) begin
            // Shift left. The old minutes digit is dropped.
            entry_mins <= entry_tens;
            entry_tens <= entry_ones;
            entry_ones <= key_digit;
          end
        end
        LD_M: begin
          state   <= LD_T;
          loadn   <= 1'b0;
          data_in <= entry_tens;
          busy    <= 1'b1;
        end
        LD_T: begin
          state   <= LD_S;
          loadn   <= 1'b0;
          data_in <= entry_ones;
          busy    <= 1'b1;
        end
        LD_S: begin
          state      <= DONE;
          load_done  <= 1'b1;
          entry_mins <= 4'd0;
          entry_tens <= 4'd0;
          entry_ones <= 4'd0;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
